regfile_scoreboard: RTL

Per-register pending-write tracker for the pipelined CPU's 32x32 register file (registered read, write on the same edge). Decode presents each instruction's source and destination registers. The block stalls issue while a source register has an outstanding write, then releases it once the write-back has landed in the register file. Only in-order issue is supported; WAW is allowed up to counter capacity.

---
 rtl/regfile_scoreboard_pkg.sv | 22 ++
 rtl/regfile_scoreboard_counter.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register-file pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Decoded view of one instruction's register usage.
  typedef struct packed {
    logic      valid;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      uses_rs;
    logic      uses_rt;
    logic      writes;
    reg_addr_t dest;
  } issue_req_t;

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// Pending-write counter for one architectural register.
module scoreboard_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic zero_c_o,
  output logic full_c_o,
  output logic underflow_c_o,
  output logic busy_d_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero_c_o      = (cnt_q == '0);
  assign full_c_o      = (cnt_q == {CNT_W{1'b1}});
  assign underflow_c_o = dec_i & zero_c_o;
  assign busy_d_c_o    = (cnt_d != '0);

  // Next count: clear wins; a matched inc/dec pair nets to no change.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !full_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !zero_c_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Tracks outstanding register-file writes and stalls issue on RAW hazards
// or when a destination's pending-write counter is saturated.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs,
  input  logic [REG_ADDR_W-1:0] issue_rt,
  input  logic                  issue_uses_rs,
  input  logic                  issue_uses_rt,
  input  logic                  issue_writes,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  issue_stall,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  flush,
  output logic [NREG-1:0]       busy_mask,
  output logic                  err_underflow
);

  issue_req_t req_c;
  logic [NREG-1:0] zero_c;
  logic [NREG-1:0] full_c;
  logic [NREG-1:0] uf_c;
  logic [NREG-1:0] inc_c;
  logic [NREG-1:0] dec_c;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;
  logic            err_q;
  logic            raw_rs_c;
  logic            raw_rt_c;
  logic            sat_c;
  logic            acc_c;

  assign req_c = '{valid: issue_valid, rs: issue_rs, rt: issue_rt,
                   uses_rs: issue_uses_rs, uses_rt: issue_uses_rt,
                   writes: issue_writes, dest: issue_dest};

  // Hazard detection from the current (pre-edge) counts only.
  assign raw_rs_c    = req_c.uses_rs & (req_c.rs != REG_ZERO) & ~zero_c[req_c.rs];
  assign raw_rt_c    = req_c.uses_rt & (req_c.rt != REG_ZERO) & ~zero_c[req_c.rt];
  assign sat_c       = req_c.writes & (req_c.dest != REG_ZERO) & full_c[req_c.dest];
  assign issue_stall = req_c.valid & (raw_rs_c | raw_rt_c | sat_c);
  assign acc_c       = req_c.valid & ~issue_stall;

  // Register 0 is hard-wired: never pending, never saturated, never underflows.
  assign zero_c[0] = 1'b1;
  assign full_c[0] = 1'b0;
  assign uf_c[0]   = 1'b0;
  assign inc_c[0]  = 1'b0;
  assign dec_c[0]  = 1'b0;
  assign busy_d[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    assign inc_c[i] = acc_c & req_c.writes & (req_c.dest == REG_ADDR_W'(i));
    assign dec_c[i] = wb_valid & (wb_dest == REG_ADDR_W'(i));

    scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .inc_i         (inc_c[i]),
      .dec_i         (dec_c[i]),
      .clr_i         (flush),
      .zero_c_o      (zero_c[i]),
      .full_c_o      (full_c[i]),
      .underflow_c_o (uf_c[i]),
      .busy_d_c_o    (busy_d[i])
    );
  end

  // Busy mask mirror and sticky underflow flag; flush clears and masks the flag.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        err_q <= 1'b0;
      end else if (|uf_c) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_mask     = busy_q;
  assign err_underflow = err_q;

endmodule
